// File: rtl/uart_tx_port_pkg.sv
// uart_tx_port_pkg: address window, register offsets and serializer states for the UART transmitter
package uart_tx_port_pkg;
  localparam logic [31:0] uart_base_addr = 32'h1000_0000;
  localparam logic [31:0] uart_top_addr = 32'h1000_000f;
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD = 2'd2;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_t;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with combinational head read
//   push/wdata enqueue, pop dequeues; rdata shows the head entry
//   full/empty/count report occupancy; contents discarded on reset
module uart_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  always_comb begin
    full = count == CW'(FIFO_DEPTH);
    empty = count == '0;
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata = mem[rd_ptr];
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clock)
    if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped 8N1 UART transmitter with TX FIFO
//   clock/reset            system clock, async active-high reset
//   uart_valid..uart_wstrb request from the SoC bus (wstrb==0 means read)
//   uart_rdata/uart_ready  one-cycle response, rdata zero outside ready
//   uart_tx                serial line, idle high
module uart_tx_port
  import uart_tx_port_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        uart_valid,
  input  logic        uart_instr,
  input  logic [31:0] uart_addr,
  input  logic [31:0] uart_wdata,
  input  logic [3:0]  uart_wstrb,
  output logic [31:0] uart_rdata,
  output logic        uart_ready,
  output logic        uart_tx
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  ser_state_t state;
  logic [CW-1:0] count;
  logic [1:0] reg_sel;
  logic [7:0] fifo_rdata, held, push_data, shreg;
  logic [15:0] baud, baud_new, cur_baud, baud_cnt;
  logic [31:0] rd_val;
  logic [2:0] bit_cnt;
  logic is_write, tx_write, hold, push, pop, full, empty, busy, waiting;
  logic unused;
  assign unused = ^{uart_instr, uart_addr[31:4], uart_addr[1:0], uart_wdata[31:16]};
  always_comb begin
    reg_sel = uart_addr[3:2];
    is_write = |uart_wstrb;
    busy = state != IDLE;
    pop = state == IDLE && !empty;
    tx_write = uart_valid && reg_sel == REG_TXDATA && uart_wstrb[0];
    // a byte for a full FIFO is parked until the serializer frees a slot
    hold = tx_write && full && !pop;
    push = (tx_write && !hold) || (waiting && pop);
    push_data = waiting ? held : uart_wdata[7:0];
    baud_new = {uart_wstrb[1] ? uart_wdata[15:8] : baud[15:8], uart_wstrb[0] ? uart_wdata[7:0] : baud[7:0]};
    rd_val = is_write ? '0 :
             reg_sel == REG_STATUS ? {16'd0, 8'(count), 5'd0, busy, empty, full} :
             reg_sel == REG_BAUD ? {16'd0, baud} : '0;
  end
  uart_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .wdata(push_data),
    .rdata(fifo_rdata),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      uart_ready <= 1'b0;
      uart_rdata <= '0;
      waiting <= 1'b0;
      held <= '0;
      baud <= 16'(CLKS_PER_BIT);
    end else begin
      uart_ready <= (uart_valid && !hold) || (waiting && pop);
      uart_rdata <= uart_valid ? rd_val : '0;
      if (hold) begin
        waiting <= 1'b1;
        held <= uart_wdata[7:0];
      end else if (waiting && pop) waiting <= 1'b0;
      if (uart_valid && reg_sel == REG_BAUD && is_write) baud <= baud_new < 16'd4 ? 16'd4 : baud_new;
    end
  // cur_baud is captured at the pop so a BAUD write never disturbs the frame in flight
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      bit_cnt <= '0;
      baud_cnt <= '0;
      cur_baud <= '0;
      shreg <= '0;
      uart_tx <= 1'b1;
    end else begin
      baud_cnt <= state == IDLE ? baud - 16'd1 : baud_cnt == '0 ? cur_baud - 16'd1 : baud_cnt - 16'd1;
      unique case (state)
        IDLE: if (!empty) begin
          state <= START;
          shreg <= fifo_rdata;
          cur_baud <= baud;
          uart_tx <= 1'b0;
        end
        START: if (baud_cnt == '0) begin
          state <= DATA;
          bit_cnt <= '0;
          {shreg, uart_tx} <= {1'b0, shreg};
        end
        DATA: if (baud_cnt == '0) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state <= STOP;
            uart_tx <= 1'b1;
          end else {shreg, uart_tx} <= {1'b0, shreg};
        end
        STOP: if (baud_cnt == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: register table, frame waveforms, full-FIFO stall, random traffic and reset abort
module tb_uart_tx_port;
  import uart_tx_port_pkg::*;
  typedef struct {
    logic [1:0] off;
    logic [31:0] wd;
    logic [3:0] ws;
    logic [31:0] exp;
  } vec_t;
  logic clock = 1'b0, reset = 1'b0, uart_valid = 1'b0, uart_instr = 1'b0;
  logic [31:0] uart_addr = '0, uart_wdata = '0, uart_rdata;
  logic [3:0] uart_wstrb = '0;
  logic uart_ready, uart_tx;
  int pass_cnt = 0, check_cnt = 0, rx_cnt = 0, mon_baud = 4;
  logic mon_en = 1'b0;
  logic [7:0] exp_q[$];
  logic wave[$];
  always #5 clock = ~clock;
  uart_tx_port dut (
    .clock(clock),
    .reset(reset),
    .uart_valid(uart_valid),
    .uart_instr(uart_instr),
    .uart_addr(uart_addr),
    .uart_wdata(uart_wdata),
    .uart_wstrb(uart_wstrb),
    .uart_rdata(uart_rdata),
    .uart_ready(uart_ready),
    .uart_tx(uart_tx)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask
  function automatic logic [31:0] addr_of(input logic [1:0] off);
    return {28'd0, off, 2'b00} | (32'($urandom) & (uart_top_addr - uart_base_addr) & 32'h3);
  endfunction
  // line level of an 8N1 frame of byte d, t clocks after the start bit begins
  function automatic logic fbit(input logic [7:0] d, input int b, input int t);
    int k;
    k = t / b;
    return k == 0 ? 1'b0 : k < 9 ? d[3'(k - 1)] : 1'b1;
  endfunction
  task automatic bus(input logic [1:0] off, input logic [31:0] wd, input logic [3:0] ws,
                     output logic [31:0] rd, output int lat);
    @(negedge clock);
    uart_valid = 1'b1;
    uart_addr = addr_of(off);
    uart_wdata = wd;
    uart_wstrb = ws;
    uart_instr = 1'($urandom);
    @(negedge clock);
    uart_valid = 1'b0;
    lat = 1;
    while (!uart_ready && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    rd = uart_rdata;
  endtask
  task automatic record(input int n);
    wave.delete();
    for (int t = 0; t < n; t++) begin
      @(negedge clock);
      wave.push_back(uart_tx);
    end
  endtask
  task automatic wait_idle(input string name);
    logic [31:0] rd;
    int lat, k;
    k = 0;
    do begin
      bus(REG_STATUS, 32'h0, 4'h0, rd, lat);
      k++;
    end while (rd != 32'h2 && k < 300);
    check(name, rd, 32'h2);
  endtask
  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(negedge clock);
      k++;
    end
    check(name, exp_q.size(), 0);
    repeat (4) @(negedge clock);
  endtask
  // receiver: samples each bit in its middle using the baud known to the bench
  initial forever begin
    @(negedge clock);
    if (mon_en && uart_tx === 1'b0) begin
      int b;
      logic [7:0] d;
      logic [8:0] e;
      b = mon_baud;
      repeat (b + b / 2) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
        d[3'(i)] = uart_tx;
        if (i < 7) repeat (b) @(negedge clock);
      end
      repeat (b) @(negedge clock);
      check("rx_stop", {31'd0, uart_tx}, 32'd1);
      e = exp_q.size() != 0 ? {1'b0, exp_q.pop_front()} : 9'h100;
      check("rx_byte", {24'd0, d}, {23'd0, e});
      rx_cnt++;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, check_cnt);
    $fatal(1);
  end
  initial begin
    vec_t vt[$];
    logic [31:0] rd;
    logic [7:0] d;
    logic [3:0] ws;
    logic e;
    int lat, errs, gap, b, n, rx0;
    vt.push_back('{REG_STATUS, 32'h0, 4'h0, 32'h2});
    vt.push_back('{REG_BAUD, 32'h0, 4'h0, 32'h364});
    vt.push_back('{REG_BAUD, 32'h2, 4'h3, 32'h0});
    vt.push_back('{REG_BAUD, 32'h0, 4'h0, 32'h4});
    vt.push_back('{REG_BAUD, 32'h12345, 4'h3, 32'h0});
    vt.push_back('{REG_BAUD, 32'h0, 4'h0, 32'h2345});
    vt.push_back('{REG_BAUD, 32'h99, 4'h1, 32'h0});
    vt.push_back('{REG_BAUD, 32'h0, 4'h0, 32'h2399});
    vt.push_back('{REG_BAUD, 32'h0, 4'h2, 32'h0});
    vt.push_back('{REG_BAUD, 32'h0, 4'h0, 32'h99});
    vt.push_back('{REG_BAUD, 32'hFFFF0003, 4'hC, 32'h0});
    vt.push_back('{REG_BAUD, 32'h0, 4'h0, 32'h99});
    vt.push_back('{REG_BAUD, 32'h3, 4'h3, 32'h0});
    vt.push_back('{REG_BAUD, 32'h0, 4'h0, 32'h4});
    vt.push_back('{2'd3, 32'hFFFFFFFF, 4'hF, 32'h0});
    vt.push_back('{2'd3, 32'h0, 4'h0, 32'h0});
    vt.push_back('{REG_TXDATA, 32'h77, 4'h2, 32'h0});
    vt.push_back('{REG_TXDATA, 32'h0, 4'h0, 32'h0});
    vt.push_back('{REG_STATUS, 32'hFFFFFFFF, 4'hF, 32'h0});
    vt.push_back('{REG_STATUS, 32'h0, 4'h0, 32'h2});
    #3 reset = 1'b1;
    #1;
    check("rst_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_ready", {31'd0, uart_ready}, 32'd0);
    check("rst_rdata", uart_rdata, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    foreach (vt[i]) begin
      bus(vt[i].off, vt[i].wd, vt[i].ws, rd, lat);
      check($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
      check($sformatf("vec%0d_lat", i), lat, 32'd1);
    end
    check("table_idle_tx", {31'd0, uart_tx}, 32'd1);
    bus(REG_TXDATA, 32'hABCDEF55, 4'b0001, rd, lat);
    check("tx55_lat", lat, 32'd1);
    fork
      record(41);
      begin
        bus(REG_STATUS, 32'h0, 4'h0, rd, lat);
        check("tx55_busy_status", rd, 32'h6);
      end
    join
    errs = 0;
    for (int t = 0; t < 41; t++) if (wave[t] !== (t < 40 ? fbit(8'h55, 4, t) : 1'b1)) errs++;
    check("tx55_wave", errs, 32'd0);
    bus(REG_STATUS, 32'h0, 4'h0, rd, lat);
    check("tx55_done_status", rd, 32'h2);
    bus(REG_TXDATA, 32'hA5, 4'b0001, rd, lat);
    fork
      record(85);
      bus(REG_TXDATA, 32'h3C, 4'b0001, rd, lat);
    join
    errs = 0;
    for (int t = 0; t < 85; t++) begin
      e = t < 40 ? fbit(8'hA5, 4, t) : (t > 40 && t < 81) ? fbit(8'h3C, 4, t - 41) : 1'b1;
      if (wave[t] !== e) errs++;
    end
    check("a53c_wave", errs, 32'd0);
    gap = 0;
    for (int t = 36; t < 85 && gap == 0; t++) if (wave[t] === 1'b0) gap = t;
    check("a53c_second_start", gap, 32'd41);
    wait_idle("a53c_idle");
    mon_baud = 4;
    mon_en = 1'b1;
    rx0 = rx_cnt;
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back(8'(i));
      bus(REG_TXDATA, 32'(i), 4'b0001, rd, lat);
      check($sformatf("fill%0d_lat", i), lat, 32'd1);
    end
    bus(REG_STATUS, 32'h0, 4'h0, rd, lat);
    check("fill_full_status", rd, 32'h1005);
    exp_q.push_back(8'h11);
    bus(REG_TXDATA, 32'h11, 4'b0001, rd, lat);
    check("full_write_lat", lat, 32'd7);
    drain("fill_drained");
    check("fill_frames", rx_cnt - rx0, 32'd18);
    wait_idle("fill_idle");
    for (int r = 0; r < 4; r++) begin
      b = int'($urandom_range(4, 9));
      bus(REG_BAUD, {16'($urandom), 16'(b)}, 4'b0011, rd, lat);
      bus(REG_BAUD, 32'h0, 4'h0, rd, lat);
      check("rnd_baud", rd, 32'(b));
      mon_baud = b;
      n = int'($urandom_range(2, 6));
      for (int j = 0; j < n; j++) begin
        d = 8'($urandom);
        if ($urandom_range(0, 3) == 0) bus(REG_TXDATA, {24'($urandom), d}, 4'b0010, rd, lat);
        else begin
          ws = 4'($urandom) | 4'b0001;
          exp_q.push_back(d);
          bus(REG_TXDATA, {24'($urandom), d}, ws, rd, lat);
        end
        check("rnd_lat", lat, 32'd1);
      end
      drain("rnd_drained");
      wait_idle("rnd_idle");
    end
    mon_en = 1'b0;
    bus(REG_BAUD, 32'h4, 4'b0011, rd, lat);
    bus(REG_TXDATA, 32'h0, 4'b0001, rd, lat);
    bus(REG_TXDATA, 32'h0, 4'b0001, rd, lat);
    repeat (16) @(negedge clock);
    check("mid_frame_tx", {31'd0, uart_tx}, 32'd0);
    #1 reset = 1'b1;
    #1;
    check("abort_tx", {31'd0, uart_tx}, 32'd1);
    check("abort_ready", {31'd0, uart_ready}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    bus(REG_STATUS, 32'h0, 4'h0, rd, lat);
    check("abort_status", rd, 32'h2);
    record(60);
    errs = 0;
    for (int t = 0; t < 60; t++) if (wave[t] !== 1'b1) errs++;
    check("abort_quiet", errs, 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
